// File: rtl/mod_invsubs.sv
// mod_invsubs: AES inverse SubBytes stage for the decryption round.
// A 16-byte state is captured on a load strobe and every byte is passed
// through the Rijndael inverse S-box, LANES bytes per clock, using LANES
// shared inverse S-box instances. The result is published atomically.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   load   - start strobe, accepted only while idle
//   p      - input state, p[i] is byte i
//   o      - substituted state, o[i] = InvSbox(p[i]); changes only on done
//   busy   - high while a block is being processed
//   done   - one-cycle pulse marking a new result on o
module mod_invsubs #(
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [15:0][7:0] p,
    output logic [15:0][7:0] o,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NGRP = 16 / LANES;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic [15:0][7:0] in_q, in_d;
    logic [15:0][7:0] work_q, work_d;
    logic [15:0][7:0] o_q, o_d;
    logic [15:0][7:0] merged;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        case (x)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
        endcase
        return r;
    endfunction

    // Work state with the current group substituted in. The loop unrolls
    // into LANES S-box copies; grp_q steers which input bytes feed them.
    always_comb begin
        logic [3:0] idx;
        idx    = '0;
        merged = work_q;
        for (int unsigned j = 0; j < LANES; j++) begin
            idx         = 4'(32'(grp_q) * LANES + j);
            merged[idx] = inv_sbox(in_q[idx]);
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        in_d    = in_q;
        work_d  = work_q;
        o_d     = o_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    in_d    = p;
                    grp_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = merged;
                if (grp_q == GW'(NGRP - 1)) begin
                    // Publish from merged rather than work_q so the last
                    // group lands in o on the same edge as the others.
                    o_d     = merged;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    grp_d   = '0;
                    state_d = IDLE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            in_q    <= '0;
            work_q  <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            in_q    <= in_d;
            work_q  <= work_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mod_invsubs.sv
// Testbench for mod_invsubs: directed vectors at LANES=4, plus LANES=1 and
// LANES=16 instances sharing one stimulus to compare latency and results.
module tb_mod_invsubs;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load, load_b;
    logic [15:0][7:0] p, p_b;
    logic [15:0][7:0] o, o1, o16;
    logic             busy, done, busy1, done1, busy16, done16;

    always #5 clk = ~clk;

    mod_invsubs #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .p(p),
        .o(o), .busy(busy), .done(done)
    );

    mod_invsubs #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load_b), .p(p_b),
        .o(o1), .busy(busy1), .done(done1)
    );

    mod_invsubs #(.LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .load(load_b), .p(p_b),
        .o(o16), .busy(busy16), .done(done16)
    );

    typedef struct {
        logic [15:0][7:0] p;
        logic [15:0][7:0] e;
    } vec_t;

    vec_t vt[5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One block on the LANES=4 instance: latency, busy span, output hold,
    // result and the single-cycle done pulse.
    task automatic run_block(input int k);
        logic [15:0][7:0] prev;
        int lat;
        bit hold_ok, busy_ok;
        prev    = o;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        @(negedge clk);
        p    = vt[k].p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat  = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (o !== prev) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", k), 128'(lat), 128'(4));
        chk($sformatf("v%0d_o", k), o, vt[k].e);
        chk($sformatf("v%0d_busy_span", k), 128'(busy_ok), 128'(1));
        chk($sformatf("v%0d_o_hold", k), 128'(hold_ok), 128'(1));
        chk($sformatf("v%0d_busy_at_done", k), 128'(busy), 128'(0));
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse_end", k), 128'(done), 128'(0));
    endtask

    initial begin
        int lat, nd, l1, l16, n1, n16;
        logic [15:0][7:0] got;
        bit hold_ok;

        // all 0x63 -> all 0x00
        vt[0].p = {16{8'h63}};
        vt[0].e = '0;
        // forward Sbox of 0x00..0x0F -> identity indices
        vt[1].p = 128'h76abd7fe2b670130c56f6bf27b777c63;
        vt[1].e = 128'h0f0e0d0c0b0a09080706050403020100;
        // single-byte spot checks in different groups, rest 0x63 -> 0x00
        vt[2].p = {16{8'h63}};
        vt[2].p[0]  = 8'h00;
        vt[2].p[5]  = 8'hff;
        vt[2].p[10] = 8'h16;
        vt[2].p[15] = 8'h7c;
        vt[2].e = '0;
        vt[2].e[0]  = 8'h52;
        vt[2].e[5]  = 8'h7d;
        vt[2].e[10] = 8'hff;
        vt[2].e[15] = 8'h01;
        // raw 0x00..0x0F -> first row of the inverse table
        vt[3].p = 128'h0f0e0d0c0b0a09080706050403020100;
        vt[3].e = 128'hfbd7f3819ea340bf38a53630d56a0952;
        // forward Sbox of 0xF0..0xFF -> 0xF0..0xFF
        vt[4].p = 128'h16bb54b00f2d99416842e6bf0d89a18c;
        vt[4].e = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;

        rst_n  = 1'b1;
        load   = 1'b0;
        load_b = 1'b0;
        p      = '0;
        p_b    = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_o", o, '0);
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_o1", o1, '0);
        chk("reset_o16", o16, '0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) run_block(k);

        // load pulses while busy must be ignored
        @(negedge clk);
        p    = vt[1].p;
        load = 1'b1;
        nd   = 0;
        got  = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                got = o;
            end
            if (c < 3) begin
                load = 1'b1;
                p    = (c % 2 == 0) ? vt[4].p : vt[2].p;
            end else begin
                load = 1'b0;
            end
        end
        chk("busy_load_done_count", 128'(nd), 128'(1));
        chk("busy_load_result", got, vt[1].e);

        // load accepted in the done cycle
        @(negedge clk);
        p    = vt[3].p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        p    = '0;
        lat  = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 128'(lat), 128'(4));
        chk("b2b_first_o", o, vt[3].e);
        p    = vt[4].p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("b2b_accepted_busy", 128'(busy), 128'(1));
        chk("b2b_done_low_after", 128'(done), 128'(0));
        lat     = 0;
        hold_ok = 1'b1;
        while (!done && lat < 40) begin
            if (o !== vt[3].e) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", 128'(lat), 128'(4));
        chk("b2b_second_o", o, vt[4].e);
        chk("b2b_first_held", 128'(hold_ok), 128'(1));

        // reset mid-RUN discards the block
        @(negedge clk);
        p    = vt[0].p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_o", o, '0);
        chk("midrun_reset_busy", 128'(busy), 128'(0));
        chk("midrun_reset_done", 128'(done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrun_no_done", 128'(nd), 128'(0));
        chk("midrun_idle_busy", 128'(busy), 128'(0));
        chk("midrun_idle_o", o, '0);

        // LANES=1 and LANES=16 on the same blocks
        for (int k = 1; k <= 3; k += 2) begin
            @(negedge clk);
            p_b    = vt[k].p;
            load_b = 1'b1;
            @(negedge clk);
            load_b = 0;
            lat = 0;
            l1  = -1;
            l16 = -1;
            n1  = 0;
            n16 = 0;
            while (lat < 30) begin
                if (done1) begin
                    n1++;
                    if (l1 < 0) l1 = lat;
                end
                if (done16) begin
                    n16++;
                    if (l16 < 0) l16 = lat;
                end
                @(negedge clk);
                lat++;
            end
            chk($sformatf("l1_v%0d_latency", k), 128'(l1), 128'(16));
            chk($sformatf("l16_v%0d_latency", k), 128'(l16), 128'(1));
            chk($sformatf("l1_v%0d_done_count", k), 128'(n1), 128'(1));
            chk($sformatf("l16_v%0d_done_count", k), 128'(n16), 128'(1));
            chk($sformatf("l1_v%0d_o", k), o1, vt[k].e);
            chk($sformatf("l16_v%0d_o", k), o16, vt[k].e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
